// File: rtl/atom_seq_divider_pkg.sv
// Shared types and helpers for the Atom sequential divider.
// Opcode encodings, FSM states, the request payload and sign helpers.
package atom_seq_divider_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIVST_IDLE = 2'd0,
        DIVST_CALC = 2'd1,
        DIVST_FIX  = 2'd2,
        DIVST_DONE = 2'd3
    } div_state_e;

    typedef struct packed {
        div_op_e           op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
    } div_req_t;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    // Two's-complement negate when n is set, modulo 2^XLEN.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
        return n ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/atom_seq_divider_if.sv
// Request/result handshake bundle between the execute stage and the divider.
interface atom_seq_divider_if;
    import atom_seq_divider_pkg::*;

    logic              req_valid;
    logic              req_ready;
    div_req_t          req;
    logic              kill;
    logic              res_valid;
    logic              res_ready;
    logic [XLEN-1:0]   result;
    logic              busy;

    modport master (
        output req_valid, req, kill, res_ready,
        input  req_ready, res_valid, result, busy
    );

    modport slave (
        input  req_valid, req, kill, res_ready,
        output req_ready, res_valid, result, busy
    );

endinterface

// File: rtl/atom_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract the divisor.
module atom_div_step
    import atom_seq_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          borrow;

    // Shifted partial remainder needs XLEN+1 bits; the top bit of the difference is the borrow.
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {1'b0, div_i};
    assign borrow  = trial[XLEN];
    assign rem_o   = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o   = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/atom_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V corner-case results.
// One request at a time; result held until the consumer handshakes or the op is killed.
module atom_seq_divider
    import atom_seq_divider_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    atom_seq_divider_if.slave   bus
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    div_op_e            op_q, op_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               ready_q, busy_q, res_valid_q;

    logic [XLEN-1:0]    step_rem, step_quo;
    logic               req_signed;
    logic [XLEN-1:0]    a_mag, b_mag;

    atom_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign req_signed = op_is_signed(bus.req.op);
    assign a_mag      = neg_if(req_signed & bus.req.a[XLEN-1], bus.req.a);
    assign b_mag      = neg_if(req_signed & bus.req.b[XLEN-1], bus.req.b);

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            DIVST_IDLE: begin
                if (bus.req_valid && !bus.kill) begin
                    op_d      = bus.req.op;
                    neg_quo_d = req_signed & (bus.req.a[XLEN-1] ^ bus.req.b[XLEN-1]);
                    neg_rem_d = req_signed & bus.req.a[XLEN-1];
                    if (bus.req.b == '0) begin
                        result_d = op_is_rem(bus.req.op) ? bus.req.a : '1;
                        state_d  = DIVST_DONE;
                    end else if (req_signed && bus.req.a == INT_MIN && bus.req.b == '1) begin
                        result_d = op_is_rem(bus.req.op) ? '0 : INT_MIN;
                        state_d  = DIVST_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        state_d = DIVST_CALC;
                    end
                end
            end
            DIVST_CALC: begin
                if (bus.kill) begin
                    cnt_d   = '0;
                    state_d = DIVST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DIVST_FIX;
                    end
                end
            end
            DIVST_FIX: begin
                if (bus.kill) begin
                    state_d = DIVST_IDLE;
                end else begin
                    result_d = op_is_rem(op_q) ? neg_if(neg_rem_q, rem_q)
                                               : neg_if(neg_quo_q, quo_q);
                    state_d  = DIVST_DONE;
                end
            end
            DIVST_DONE: begin
                if (bus.kill || bus.res_ready) begin
                    state_d = DIVST_IDLE;
                end
            end
            default: state_d = DIVST_IDLE;
        endcase
    end

    // State and registered handshake outputs, decoded from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DIVST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            op_q        <= DIV_OP_DIV;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            op_q        <= op_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            ready_q     <= (state_d == DIVST_IDLE);
            busy_q      <= (state_d != DIVST_IDLE);
            res_valid_q <= (state_d == DIVST_DONE);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_atom_seq_divider.sv
// Directed-vector and random self-checking bench for atom_seq_divider.
module tb_atom_seq_divider;
    import atom_seq_divider_pkg::*;

    localparam int NORM_LAT = 34;
    localparam int SPEC_LAT = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    atom_seq_divider_if bus();

    atom_seq_divider dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        div_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference using SV signed/unsigned operators plus RISC-V corner rules
    function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sr;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            return (op == DIV_OP_REM || op == DIV_OP_REMU) ? a : 32'hFFFF_FFFF;
        end
        case (op)
            DIV_OP_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            DIV_OP_REM: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            DIV_OP_DIVU: return a / b;
            default:     return a % b;
        endcase
    endfunction

    // Issue one op, change operands right after accept, check latency/result/handshake.
    task automatic do_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        chk({name, "_ready_pre"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req       = '{op: op, a: a, b: b};
        step();
        bus.req_valid = 1'b0;
        bus.req       = '{op: op, a: ~a, b: ~b};
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, bus.result, exp);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk({name, "_valid_post"}, 32'(bus.res_valid), 32'd0);
        chk({name, "_ready_post"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Accept one request and return right after the accept edge.
    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req       = '{op: op, a: a, b: b};
        step();
        bus.req_valid = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        int          n;
        int          lat;
        int          seen;
        div_op_e     rop;
        logic [31:0] ra, rb, rexp;

        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req       = '{op: DIV_OP_DIV, a: 32'h0, b: 32'h0};
        bus.kill      = 1'b0;
        bus.res_ready = 1'b0;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,       32'd7,        32'd14,        NORM_LAT};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,       32'd7,        32'd2,         NORM_LAT};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NORM_LAT};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NORM_LAT};
        vecs[4]  = '{DIV_OP_DIV,  32'd5,         32'd0,        32'hFFFF_FFFF, SPEC_LAT};
        vecs[5]  = '{DIV_OP_REMU, 32'd5,         32'd0,        32'd5,         SPEC_LAT};
        vecs[6]  = '{DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT};
        vecs[7]  = '{DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        SPEC_LAT};
        vecs[8]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, NORM_LAT};
        vecs[9]  = '{DIV_OP_REM,  32'hFFFF_FFF8, 32'd3,        32'hFFFF_FFFE, NORM_LAT};
        vecs[10] = '{DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        NORM_LAT};
        vecs[11] = '{DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,        NORM_LAT};
        vecs[12] = '{DIV_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT};
        vecs[13] = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, SPEC_LAT};

        step();
        step();
        rst = 1'b0;
        chk("rst_ready",  32'(bus.req_ready), 32'd1);
        chk("rst_valid",  32'(bus.res_valid), 32'd0);
        chk("rst_busy",   32'(bus.busy),      32'd0);
        chk("rst_result", bus.result,         32'd0);

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                  $sformatf("vec%0d", i));
        end

        // Back-pressure: result and flags hold while res_ready stays low
        issue(DIV_OP_DIVU, 32'd1000, 32'd10);
        n = 1;
        while (!bus.res_valid && n < 100) begin
            step();
            n++;
        end
        chk("stall_lat", 32'(n), 32'(NORM_LAT));
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_valid%0d", i), 32'(bus.res_valid), 32'd1);
            chk($sformatf("stall_res%0d", i),   bus.result,         32'd100);
            chk($sformatf("stall_ready%0d", i), 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("stall_release", 32'(bus.res_valid), 32'd0);

        // Kill during CALC cycle 10
        issue(DIV_OP_DIVU, 32'd5000, 32'd3);
        for (int i = 0; i < 9; i++) step();
        chk("kill_busy_pre", 32'(bus.busy), 32'd1);
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
        chk("kill_ready", 32'(bus.req_ready), 32'd1);
        chk("kill_busy",  32'(bus.busy),      32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.res_valid) seen++;
            step();
        end
        chk("kill_no_valid", 32'(seen), 32'd0);
        chk("kill_result_held", bus.result, 32'd100);

        // Kill in IDLE blocks accept
        bus.req_valid = 1'b1;
        bus.req       = '{op: DIV_OP_DIVU, a: 32'd9, b: 32'd3};
        bus.kill      = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        chk("kill_idle_busy",  32'(bus.busy),      32'd0);
        chk("kill_idle_ready", 32'(bus.req_ready), 32'd1);

        // Kill in DONE wins over res_ready
        issue(DIV_OP_DIV, 32'd5, 32'd0);
        chk("kdone_valid", 32'(bus.res_valid), 32'd1);
        bus.kill      = 1'b1;
        bus.res_ready = 1'b1;
        step();
        bus.kill      = 1'b0;
        bus.res_ready = 1'b0;
        chk("kdone_valid_post", 32'(bus.res_valid), 32'd0);
        chk("kdone_ready_post", 32'(bus.req_ready), 32'd1);

        // Random ops against the reference model
        for (int i = 0; i < 300; i++) begin
            rop = div_op_e'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 100);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            rexp = model(rop, ra, rb);
            lat  = (rb == 32'd0 ||
                    ((rop == DIV_OP_DIV || rop == DIV_OP_REM) &&
                     ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? SPEC_LAT : NORM_LAT;
            do_op(rop, ra, rb, rexp, lat, $sformatf("rnd%0d", i));
        end

        // Reset mid-CALC returns everything to reset values
        issue(DIV_OP_DIVU, 32'd77, 32'd5);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstm_ready",  32'(bus.req_ready), 32'd1);
        chk("rstm_valid",  32'(bus.res_valid), 32'd0);
        chk("rstm_busy",   32'(bus.busy),      32'd0);
        chk("rstm_result", bus.result,         32'd0);
        do_op(DIV_OP_REMU, 32'd77, 32'd5, 32'd2, NORM_LAT, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
